// File: rtl/seg7_capture_if.sv
// rtl/seg7_capture_if.sv - seven-segment bus pins and captured-digit outputs
interface seg7_capture_if;
  logic        ca, cb, cc, cd, ce, cf, cg;
  logic        an0, an1, an2, an3, an4, an5, an6, an7;
  logic [31:0] digits;
  logic [7:0]  valid;
  logic [7:0]  err;
  logic        frame_done;
  logic        bad_an;

  modport master (
    output ca, cb, cc, cd, ce, cf, cg,
    output an0, an1, an2, an3, an4, an5, an6, an7,
    input  digits, valid, err, frame_done, bad_an
  );

  modport slave (
    input  ca, cb, cc, cd, ce, cf, cg,
    input  an0, an1, an2, an3, an4, an5, an6, an7,
    output digits, valid, err, frame_done, bad_an
  );
endinterface

// File: rtl/seg7_capture.sv
// rtl/seg7_capture.sv - passive decoder of a multiplexed active-low 8-digit seven-segment bus
module seg7_capture #(
  parameter int STABLE_CYCLES = 16
) (
  input  logic          clk,
  input  logic          rst,
  seg7_capture_if.slave bus
);

  localparam logic [9:0] STABLE    = 10'(STABLE_CYCLES);
  localparam logic [9:0] STABLE_M1 = 10'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {SETTLE, CAPTURE, HOLD} state_t;

  state_t      state_q, state_d;
  logic [7:0]  an_q, an_d;
  logic [6:0]  seg_q, seg_d;
  logic [9:0]  cnt_q, cnt_d;
  logic [31:0] digits_q, digits_d;
  logic [7:0]  valid_q, valid_d;
  logic [7:0]  err_q, err_d;
  logic [7:0]  seen_q, seen_d;
  logic        frame_done_q, frame_done_d;
  logic        bad_an_q, bad_an_d;

  logic        changed;
  logic        capture;
  logic        multi;
  logic [7:0]  low;
  logic [7:0]  seen_set;
  logic [2:0]  idx;
  logic [4:0]  dec;

  // Returns {legal, value}; legal=0 for anything outside the hex glyph set.
  function automatic logic [4:0] decode(input logic [6:0] seg);
    case (seg)
      7'b1000000: decode = {1'b1, 4'h0};
      7'b1111001: decode = {1'b1, 4'h1};
      7'b0100100: decode = {1'b1, 4'h2};
      7'b0110000: decode = {1'b1, 4'h3};
      7'b0011001: decode = {1'b1, 4'h4};
      7'b0010010: decode = {1'b1, 4'h5};
      7'b0000010: decode = {1'b1, 4'h6};
      7'b1111000: decode = {1'b1, 4'h7};
      7'b0000000: decode = {1'b1, 4'h8};
      7'b0010000: decode = {1'b1, 4'h9};
      7'b0001000: decode = {1'b1, 4'hA};
      7'b0000011: decode = {1'b1, 4'hB};
      7'b1000110: decode = {1'b1, 4'hC};
      7'b0100001: decode = {1'b1, 4'hD};
      7'b0000110: decode = {1'b1, 4'hE};
      7'b0001110: decode = {1'b1, 4'hF};
      default:    decode = 5'b0_0000;
    endcase
  endfunction

  always_comb begin
    an_d  = {bus.an7, bus.an6, bus.an5, bus.an4, bus.an3, bus.an2, bus.an1, bus.an0};
    seg_d = {bus.cg, bus.cf, bus.ce, bus.cd, bus.cc, bus.cb, bus.ca};

    changed = (an_d != an_q) || (seg_d != seg_q);
    low     = ~an_q;
    multi   = (low & (low - 8'd1)) != 8'd0;
    idx     = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (low[i]) idx = 3'(i);
    end
    dec      = decode(seg_q);
    seen_set = seen_q | (8'd1 << idx);

    // The held sample S is what gets decoded, so the capture edge uses the settled value.
    capture = !changed && (state_q == SETTLE) && (cnt_q == STABLE_M1);

    cnt_d = cnt_q;
    if (changed)              cnt_d = 10'd0;
    else if (cnt_q != STABLE) cnt_d = cnt_q + 10'd1;

    if (changed)                                      state_d = SETTLE;
    else if (capture)                                 state_d = CAPTURE;
    else if (state_q == CAPTURE || state_q == HOLD)   state_d = HOLD;
    else                                              state_d = SETTLE;

    digits_d     = digits_q;
    valid_d      = valid_q;
    err_d        = err_q;
    seen_d       = seen_q;
    frame_done_d = 1'b0;
    bad_an_d     = 1'b0;

    if (capture) begin
      if (multi) begin
        bad_an_d = 1'b1;
      end else if (low != 8'd0) begin
        digits_d[{idx, 2'b00} +: 4] = dec[4] ? dec[3:0] : 4'h0;
        valid_d[idx]                = dec[4];
        err_d[idx]                  = !dec[4] && (seg_q != 7'h7F);
        // Completing the set pulses frame_done and starts the next frame empty.
        if (&seen_set) begin
          frame_done_d = 1'b1;
          seen_d       = 8'd0;
        end else begin
          seen_d = seen_set;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= SETTLE;
      an_q         <= 8'hFF;
      seg_q        <= 7'h7F;
      cnt_q        <= 10'd0;
      digits_q     <= 32'd0;
      valid_q      <= 8'd0;
      err_q        <= 8'd0;
      seen_q       <= 8'd0;
      frame_done_q <= 1'b0;
      bad_an_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      cnt_q        <= cnt_d;
      digits_q     <= digits_d;
      valid_q      <= valid_d;
      err_q        <= err_d;
      seen_q       <= seen_d;
      frame_done_q <= frame_done_d;
      bad_an_q     <= bad_an_d;
    end
  end

  assign bus.digits     = digits_q;
  assign bus.valid      = valid_q;
  assign bus.err        = err_q;
  assign bus.frame_done = frame_done_q;
  assign bus.bad_an     = bad_an_q;

endmodule

// File: tb/tb_seg7_capture.sv
// tb/tb_seg7_capture.sv - directed bench with a run-length reference model of seg7_capture
module tb_seg7_capture;
  localparam int STABLE = 16;

  logic clk = 1'b0;
  logic rst;
  logic [7:0] an_v;
  logic [6:0] seg_v;
  logic armed = 1'b0;
  int checks = 0;
  int errors = 0;
  int frame_cnt = 0;
  int bad_cnt = 0;
  int fc0, bc0;

  always #5 clk = ~clk;

  seg7_capture_if bus ();
  seg7_capture #(.STABLE_CYCLES(STABLE)) dut (.clk(clk), .rst(rst), .bus(bus));

  assign {bus.an7, bus.an6, bus.an5, bus.an4, bus.an3, bus.an2, bus.an1, bus.an0} = an_v;
  assign {bus.cg, bus.cf, bus.ce, bus.cd, bus.cc, bus.cb, bus.ca} = seg_v;

  logic [6:0] pat [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Model: a value captured once the pins have been sampled unchanged on STABLE+1 edges.
  logic [14:0] prev;
  int          run;
  logic [3:0]  m_dig [8];
  logic [7:0]  m_val, m_err, m_seen;
  logic        m_frame, m_bad;

  task automatic model_apply(input logic [14:0] cur);
    int nlow, k, hit;
    nlow = 0; k = 0; hit = -1;
    for (int i = 0; i < 8; i++) if (!cur[7 + i]) begin nlow++; k = i; end
    if (nlow >= 2) m_bad = 1'b1;
    else if (nlow == 1) begin
      for (int v = 0; v < 16; v++) if (pat[v] == cur[6:0]) hit = v;
      m_dig[k] = (hit >= 0) ? 4'(hit) : 4'h0;
      m_val[k] = (hit >= 0);
      m_err[k] = (hit < 0) && (cur[6:0] != 7'h7F);
      m_seen[k] = 1'b1;
      if (m_seen == 8'hFF) begin m_frame = 1'b1; m_seen = 8'h00; end
    end
  endtask

  always @(posedge clk) begin
    m_frame = 1'b0;
    m_bad   = 1'b0;
    if (rst) begin
      prev = 15'h7FFF; run = 1;
      for (int i = 0; i < 8; i++) m_dig[i] = 4'h0;
      m_val = 8'h00; m_err = 8'h00; m_seen = 8'h00;
    end else begin
      if ({an_v, seg_v} == prev) run++;
      else begin prev = {an_v, seg_v}; run = 1; end
      if (run == STABLE + 1) model_apply(prev);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic [31:0] e;
    if (armed) begin
      for (int k = 0; k < 8; k++) e[k*4 +: 4] = m_dig[k];
      chk("model_digits", bus.digits, e);
      chk("model_valid", 32'(bus.valid), 32'(m_val));
      chk("model_err", 32'(bus.err), 32'(m_err));
      chk("model_frame_done", 32'(bus.frame_done), 32'(m_frame));
      chk("model_bad_an", 32'(bus.bad_an), 32'(m_bad));
      if (bus.frame_done) frame_cnt++;
      if (bus.bad_an) bad_cnt++;
    end
  end

  function automatic logic [7:0] sel(input int k);
    return ~(8'd1 << k);
  endfunction

  task automatic step(input logic [7:0] an, input logic [6:0] seg, input int n);
    an_v = an; seg_v = seg;
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    int v1 [8];
    int v2 [8];
    v1 = '{0, 1, 2, 3, 10, 11, 12, 13};
    v2 = '{8, 9, 10, 11, 12, 13, 14, 15};
    rst = 1'b1; an_v = 8'hFF; seg_v = 7'h7F;
    repeat (2) @(posedge clk);
    #2; rst = 1'b0; armed = 1'b1;
    chk("reset_digits", bus.digits, 32'h0);
    chk("reset_valid", 32'(bus.valid), 32'h0);
    chk("reset_err", 32'(bus.err), 32'h0);

    // Capture latency: digit 3 must appear on the 16th edge after the sampling edge.
    step(8'hFF, 7'h7F, 3);
    an_v = sel(3); seg_v = 7'h30;
    @(posedge clk);
    repeat (15) @(posedge clk);
    #1;
    chk("t1_before_capture", 32'(bus.digits[15:12]), 32'h0);
    chk("t1_valid_before", 32'(bus.valid), 32'h00);
    @(posedge clk); #1;
    chk("t1_capture_digit", 32'(bus.digits[15:12]), 32'h3);
    chk("t1_capture_valid", 32'(bus.valid), 32'h08);
    #1;
    step(sel(3), 7'h30, 4);

    fc0 = frame_cnt;
    for (int k = 0; k < 8; k++) begin
      step(sel(k), pat[v1[k]], 100);
      if (k == 6) chk("t2_no_early_frame", 32'(frame_cnt - fc0), 32'd0);
    end
    chk("t2_frame_count", 32'(frame_cnt - fc0), 32'd1);
    chk("t2_digits", bus.digits, 32'hDCBA3210);
    chk("t2_valid", 32'(bus.valid), 32'hFF);
    chk("t2_err", 32'(bus.err), 32'h00);

    fc0 = frame_cnt;
    for (int k = 0; k < 8; k++) begin
      if (k == 2) begin
        step(sel(2), pat[v2[2]], 5);
        step(sel(2), 7'h7F, 16);
        step(sel(2), pat[v2[2]], 79);
      end else begin
        step(sel(k), pat[v2[k]], 100);
      end
    end
    chk("t3_frame_count", 32'(frame_cnt - fc0), 32'd1);
    chk("t3_digits", bus.digits, 32'hFEDCBA98);
    chk("t3_valid", 32'(bus.valid), 32'hFF);

    step(sel(5), 7'h55, 20);
    chk("t4_illegal_err", 32'(bus.err), 32'h20);
    chk("t4_illegal_valid", 32'(bus.valid), 32'hDF);
    chk("t4_illegal_digit", 32'(bus.digits[23:20]), 32'h0);
    step(sel(5), pat[7], 20);
    chk("t4_recover_err", 32'(bus.err), 32'h00);
    chk("t4_recover_digit", 32'(bus.digits[23:20]), 32'h7);

    fc0 = frame_cnt; bc0 = bad_cnt;
    step(8'b1110_1101, pat[5], 20);
    chk("t5_bad_an_count", 32'(bad_cnt - bc0), 32'd1);
    chk("t5_digits_kept", bus.digits, 32'hFE7CBA98);
    chk("t5_valid_kept", 32'(bus.valid), 32'hFF);
    chk("t5_no_frame", 32'(frame_cnt - fc0), 32'd0);

    step(8'hFF, 7'h7F, 20);
    for (int k = 0; k < 5; k++) step(sel(k), pat[k + 1], 30);
    chk("t6_pre_reset_digits", bus.digits, 32'hFE754321);
    rst = 1'b1; an_v = 8'hFF; seg_v = 7'h7F;
    @(posedge clk); #1;
    chk("t6_reset_digits", bus.digits, 32'h0);
    chk("t6_reset_valid", 32'(bus.valid), 32'h0);
    chk("t6_reset_err", 32'(bus.err), 32'h0);
    #1; rst = 1'b0;
    fc0 = frame_cnt;
    for (int k = 0; k < 8; k++) begin
      step(sel(k), pat[7 - k], 30);
      if (k == 6) chk("t6_no_early_frame", 32'(frame_cnt - fc0), 32'd0);
    end
    chk("t6_frame_count", 32'(frame_cnt - fc0), 32'd1);
    chk("t6_digits", bus.digits, 32'h01234567);
    chk("t6_valid", 32'(bus.valid), 32'hFF);

    step(8'hFF, 7'h7F, 5);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
